dram_rd_arbiter: RTL and testbench
==================================

DRAM_RD_ARBITER -- requirements
Module: dram_rd_arbiter

Interface
REQ-001 Parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 Parameter DATA_WIDTH, default 16, AXI data width.
REQ-004 Timing is fixed as follows: one clock; reset is synchronous and active-low; ports clk, rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid / req1_valid  in  1  read request, requester 0 (instruction fill) / 1 (data fill).
- req0_addr / req1_addr  in  ADDR_WIDTH  burst start byte address.
- req0_len / req1_len  in  7  AXI arlen (beats-1).
- req0_ready / req1_ready  out  1  request accepted this cycle.
- rsp_valid  out  1  read beat valid.
- rsp_data  out  DATA_WIDTH  beat data.
- rsp_last  out  1  final beat of burst.
- rsp_sel  out  1  owning requester of the current beat.
- rsp_err  out  1  beat carried rresp != 0.
- proto_err  out  1  sticky: rlast arrived on a beat index other than len.
- busy  out  1  state != IDLE.
- arid_m_inf  out  ID_WIDTH; araddr_m_inf  out  ADDR_WIDTH; arlen_m_inf  out  7; arsize_m_inf  out  3; arburst_m_inf  out  2; arvalid_m_inf  out  1; arready_m_inf  in  1.
- rid_m_inf  in  ID_WIDTH; rdata_m_inf  in  DATA_WIDTH; rresp_m_inf  in  2; rlast_m_inf  in  1; rvalid_m_inf  in  1; rready_m_inf  out  1.

Function
REQ-006 FSM states SHALL be IDLE, ADDR, DATA.
REQ-007 In IDLE, the grant SHALL be the single valid requester. If both are valid, the grant SHALL go to the requester not recorded in last_gnt (round-robin).
REQ-008 reqN_ready SHALL be combinational: high only in IDLE and only for the granted N. It SHALL never be high for both requesters.
REQ-009 On reqN_valid && reqN_ready:
- latch addr, len and sel=N;
- set last_gnt=N;
- reset the beat counter to 0;
- go to ADDR next cycle.
REQ-010 In ADDR:
- arvalid_m_inf=1;
- araddr/arlen driven from the latches and held stable until arready_m_inf;
- arid_m_inf=0, arsize_m_inf=3'b001, arburst_m_inf=2'b01 (INCR).
REQ-011 When arvalid_m_inf && arready_m_inf, go to DATA next cycle. arready already high on the first ADDR cycle SHALL give a 1-cycle ADDR phase.
REQ-012 In DATA, rready_m_inf=1. Outside DATA, rready_m_inf=0 and arvalid_m_inf=0.
REQ-013 In DATA, the response path SHALL be combinational pass-through:
- rsp_valid = rvalid_m_inf;
- rsp_data = rdata_m_inf;
- rsp_last = rlast_m_inf;
- rsp_err = (rresp_m_inf != 0);
- rsp_sel = latched sel.
REQ-014 Each rvalid beat in DATA SHALL increment the 7-bit beat counter.
REQ-015 On a beat with rlast_m_inf=1:
- if counter != latched len, set proto_err;
- return to IDLE next cycle.
REQ-016 Beats with rlast=0 SHALL never leave DATA, even when the counter passes len. The counter SHALL wrap at 127.
REQ-017 len=0 SHALL produce a single-beat burst. rlast on the first beat with counter=0 SHALL NOT set proto_err.
REQ-018 Latency: accept at cycle T gives arvalid at T+1. The rlast handshake at cycle T makes the block IDLE at T+1, so the next accept can occur at T+1 and its arvalid at T+2.
REQ-019 A requester dropping valid in IDLE before it is accepted SHALL cause no grant and no change to last_gnt.
REQ-020 Requests arriving during ADDR or DATA SHALL be held off (ready=0) and arbitrated in IDLE.
REQ-021 The latched address, len and sel SHALL not change from accept until return to IDLE.

Reset
REQ-022 When rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- set last_gnt=1 (requester 0 wins the first tie);
- clear proto_err, the beat counter, and the address/len/sel latches.
REQ-023 During and after reset, every output SHALL be 0 until the next request, including arvalid_m_inf, rready_m_inf, rsp_*, reqN_ready (while no request), busy and all AR fields.
REQ-024 Reset mid-burst (ADDR or DATA) SHALL abandon the burst immediately; no further rsp_valid SHALL be emitted.

Verification
REQ-025 Single request: req0 addr=0x1000, len=15, arready after 2 cycles → one AR with araddr=0x1000, arlen=15; 16 rsp beats with rsp_sel=0; rsp_last on beat 16; busy falls the next cycle.
REQ-026 Tie: req0 and req1 valid together and held from reset → grants alternate 0,1,0,1; no cycle has both readies high.
REQ-027 len=0 with arready=1 in the same cycle as arvalid → ADDR lasts 1 cycle; one beat; proto_err stays 0.
REQ-028 rlast on beat 4 with len=7 → proto_err=1 (sticky); FSM returns to IDLE; the next request is served normally.
REQ-029 rresp=2'b10 on beat 2 → rsp_err=1 on that beat only; burst completes.
REQ-030 rst_n=0 during DATA beat 3 of 8 → IDLE next cycle; all outputs 0; later rvalid pulses produce no rsp_valid.

Source files
------------

// File: rtl/dram_rd_arbiter_if.sv
// dram_rd_arbiter_if: requester, response and AXI read-channel signals of the arbiter
interface dram_rd_arbiter_if #(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr;
  logic [6:0] req0_len, req1_len;
  logic rsp_valid, rsp_last, rsp_sel, rsp_err, proto_err, busy;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ID_WIDTH-1:0] arid_m_inf, rid_m_inf;
  logic [ADDR_WIDTH-1:0] araddr_m_inf;
  logic [6:0] arlen_m_inf;
  logic [2:0] arsize_m_inf;
  logic [1:0] arburst_m_inf, rresp_m_inf;
  logic arvalid_m_inf, arready_m_inf, rlast_m_inf, rvalid_m_inf, rready_m_inf;
  logic [DATA_WIDTH-1:0] rdata_m_inf;
  modport slave (
    input req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len,
    input arready_m_inf, rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_last, rsp_sel, rsp_err, proto_err, busy,
    output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf, rready_m_inf
  );
  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len,
    output arready_m_inf, rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    input req0_ready, req1_ready, rsp_valid, rsp_data, rsp_last, rsp_sel, rsp_err, proto_err, busy,
    input arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf, rready_m_inf
  );
endinterface

// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: round-robin arbiter of two read requesters onto one AXI read master
module dram_rd_arbiter #(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  dram_rd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic last_gnt_q, last_gnt_d, sel_q, sel_d, proto_err_q, proto_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [6:0] len_q, len_d, cnt_q, cnt_d;
  logic gnt, acc, beat, idle, in_addr, in_data;
  always_comb begin
    idle = state_q == IDLE;
    in_addr = state_q == ADDR;
    in_data = state_q == DATA;
    gnt = (bus.req0_valid & bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;
    bus.req0_ready = idle & bus.req0_valid & ~gnt;
    bus.req1_ready = idle & bus.req1_valid & gnt;
    acc = bus.req0_ready | bus.req1_ready;
    beat = in_data & bus.rvalid_m_inf;
    state_d = idle ? (acc ? ADDR : IDLE)
            : in_addr ? (bus.arready_m_inf ? DATA : ADDR)
            : ((beat & bus.rlast_m_inf) ? IDLE : DATA);
    last_gnt_d = acc ? gnt : last_gnt_q;
    sel_d = acc ? gnt : sel_q;
    addr_d = acc ? (gnt ? bus.req1_addr : bus.req0_addr) : addr_q;
    len_d = acc ? (gnt ? bus.req1_len : bus.req0_len) : len_q;
    cnt_d = acc ? 7'd0 : beat ? cnt_q + 7'd1 : cnt_q;
    proto_err_d = proto_err_q | (beat & bus.rlast_m_inf & (cnt_q != len_q));
    bus.arvalid_m_inf = in_addr;
    bus.arid_m_inf = ID_WIDTH'(0);
    bus.araddr_m_inf = in_addr ? addr_q : '0;
    bus.arlen_m_inf = in_addr ? len_q : 7'd0;
    bus.arsize_m_inf = in_addr ? 3'b001 : 3'b000;
    bus.arburst_m_inf = in_addr ? 2'b01 : 2'b00;
    bus.rready_m_inf = in_data;
    bus.rsp_valid = in_data & bus.rvalid_m_inf;
    bus.rsp_data = in_data ? bus.rdata_m_inf : DATA_WIDTH'(0);
    bus.rsp_last = in_data & bus.rlast_m_inf;
    bus.rsp_err = in_data & (bus.rresp_m_inf != 2'b00);
    bus.rsp_sel = in_data & sel_q;
    bus.proto_err = proto_err_q;
    bus.busy = ~idle;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_gnt_q <= 1'b1;
      sel_q <= 1'b0;
      addr_q <= '0;
      len_q <= 7'd0;
      cnt_q <= 7'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_gnt_q <= last_gnt_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_dram_rd_arbiter.sv
// tb_dram_rd_arbiter: directed and randomized checking against a transaction-level model
module tb_dram_rd_arbiter;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dram_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dram_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  bit m_active, m_ar_done, m_owner, m_prev, m_perr;
  logic [AW-1:0] m_addr;
  int m_len, m_total, tgt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_active = 0;
    m_ar_done = 0;
    m_owner = 0;
    m_prev = 1;
    m_perr = 0;
    m_addr = '0;
    m_len = 0;
    m_total = 0;
  endtask
  function automatic bit win0();
    return !m_active && bus.req0_valid && (!bus.req1_valid || m_prev);
  endfunction
  function automatic bit win1();
    return !m_active && bus.req1_valid && (!bus.req0_valid || !m_prev);
  endfunction
  task automatic compare_model();
    bit arv, dat;
    arv = m_active && !m_ar_done;
    dat = m_active && m_ar_done;
    chk("req0_ready", bus.req0_ready, win0());
    chk("req1_ready", bus.req1_ready, win1());
    chk("both_ready", bus.req0_ready & bus.req1_ready, 0);
    chk("arvalid", bus.arvalid_m_inf, arv);
    chk("araddr", bus.araddr_m_inf, arv ? m_addr : 0);
    chk("arlen", bus.arlen_m_inf, arv ? m_len : 0);
    chk("arsize", bus.arsize_m_inf, arv ? 1 : 0);
    chk("arburst", bus.arburst_m_inf, arv ? 1 : 0);
    chk("arid", bus.arid_m_inf, 0);
    chk("rready", bus.rready_m_inf, dat);
    chk("rsp_valid", bus.rsp_valid, dat && bus.rvalid_m_inf);
    chk("rsp_data", bus.rsp_data, dat ? bus.rdata_m_inf : 0);
    chk("rsp_last", bus.rsp_last, dat && bus.rlast_m_inf);
    chk("rsp_err", bus.rsp_err, dat && (bus.rresp_m_inf != 0));
    chk("rsp_sel", bus.rsp_sel, dat ? m_owner : 0);
    chk("proto_err", bus.proto_err, m_perr);
    chk("busy", bus.busy, m_active);
  endtask
  task automatic model_update();
    bit w0, w1;
    w0 = win0();
    w1 = win1();
    if (!rst_n) model_reset();
    else if (!m_active) begin
      if (w0 || w1) begin
        m_active = 1;
        m_ar_done = 0;
        m_owner = w1;
        m_prev = w1;
        m_addr = w1 ? bus.req1_addr : bus.req0_addr;
        m_len = w1 ? bus.req1_len : bus.req0_len;
        m_total = 0;
      end
    end else if (!m_ar_done) begin
      if (bus.arready_m_inf) m_ar_done = 1;
    end else if (bus.rvalid_m_inf) begin
      if (bus.rlast_m_inf) begin
        if ((m_total % 128) != m_len) m_perr = 1;
        m_active = 0;
      end
      m_total++;
    end
  endtask
  task automatic settle();
    #1;
    compare_model();
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_inputs();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.req0_addr = '0;
    bus.req1_addr = '0;
    bus.req0_len = 7'd0;
    bus.req1_len = 7'd0;
    bus.arready_m_inf = 0;
    bus.rid_m_inf = '0;
    bus.rdata_m_inf = '0;
    bus.rresp_m_inf = 2'b00;
    bus.rlast_m_inf = 0;
    bus.rvalid_m_inf = 0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    settle();
    tick();
    settle();
    chk("rst_busy", bus.busy, 0);
    chk("rst_arvalid", bus.arvalid_m_inf, 0);
    chk("rst_rready", bus.rready_m_inf, 0);
    tick();
    rst_n = 1;
  endtask
  initial begin
    bit found;
    model_reset();
    clear_inputs();
    @(negedge clk);
    do_reset();
    bus.req0_valid = 1;
    bus.req0_addr = 32'h1000;
    bus.req0_len = 7'd15;
    settle();
    chk("single_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      bus.arready_m_inf = (i == 2);
      settle();
      chk("single_arvalid", bus.arvalid_m_inf, 1);
      chk("single_araddr", bus.araddr_m_inf, 32'h1000);
      chk("single_arlen", bus.arlen_m_inf, 15);
      tick();
    end
    bus.arready_m_inf = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rvalid_m_inf = 1;
      bus.rdata_m_inf = DW'(i * 3 + 1);
      bus.rlast_m_inf = (i == 15);
      bus.rresp_m_inf = (i == 1) ? 2'b10 : 2'b00;
      settle();
      chk("single_rsp_valid", bus.rsp_valid, 1);
      chk("single_rsp_sel", bus.rsp_sel, 0);
      chk("single_rsp_last", bus.rsp_last, i == 15);
      chk("single_rsp_err", bus.rsp_err, i == 1);
      chk("single_rsp_data", bus.rsp_data, DW'(i * 3 + 1));
      tick();
    end
    clear_inputs();
    settle();
    chk("single_busy_fall", bus.busy, 0);
    chk("single_no_perr", bus.proto_err, 0);
    tick();
    bus.req1_valid = 1;
    bus.req1_addr = 32'h2468;
    bus.req1_len = 7'd0;
    settle();
    chk("len0_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    bus.arready_m_inf = 1;
    settle();
    chk("len0_arvalid", bus.arvalid_m_inf, 1);
    chk("len0_araddr", bus.araddr_m_inf, 32'h2468);
    tick();
    clear_inputs();
    bus.rvalid_m_inf = 1;
    bus.rlast_m_inf = 1;
    settle();
    chk("len0_rready", bus.rready_m_inf, 1);
    chk("len0_rsp_last", bus.rsp_last, 1);
    chk("len0_rsp_sel", bus.rsp_sel, 1);
    tick();
    clear_inputs();
    settle();
    chk("len0_busy", bus.busy, 0);
    chk("len0_perr", bus.proto_err, 0);
    tick();
    bus.req0_valid = 1;
    bus.req0_addr = 32'h3000;
    bus.req0_len = 7'd7;
    settle();
    chk("early_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    bus.arready_m_inf = 1;
    settle();
    tick();
    bus.arready_m_inf = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid_m_inf = 1;
      bus.rlast_m_inf = (i == 3);
      settle();
      tick();
    end
    clear_inputs();
    settle();
    chk("early_perr", bus.proto_err, 1);
    chk("early_idle", bus.busy, 0);
    tick();
    bus.req1_valid = 1;
    bus.req1_addr = 32'h4000;
    bus.req1_len = 7'd1;
    settle();
    chk("after_err_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    bus.arready_m_inf = 1;
    settle();
    chk("after_err_araddr", bus.araddr_m_inf, 32'h4000);
    tick();
    bus.arready_m_inf = 0;
    for (int i = 0; i < 2; i++) begin
      bus.rvalid_m_inf = 1;
      bus.rlast_m_inf = (i == 1);
      settle();
      chk("after_err_sel", bus.rsp_sel, 1);
      tick();
    end
    clear_inputs();
    settle();
    chk("perr_sticky", bus.proto_err, 1);
    tick();
    bus.req0_valid = 1;
    bus.req0_addr = 32'h5000;
    bus.req0_len = 7'd7;
    settle();
    tick();
    bus.req0_valid = 0;
    bus.arready_m_inf = 1;
    settle();
    tick();
    bus.arready_m_inf = 0;
    for (int i = 0; i < 3; i++) begin
      bus.rvalid_m_inf = 1;
      rst_n = (i != 2);
      settle();
      tick();
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      bus.rvalid_m_inf = 1;
      bus.rlast_m_inf = (i == 1);
      settle();
      chk("midrst_rsp_valid", bus.rsp_valid, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_perr", bus.proto_err, 0);
      tick();
    end
    do_reset();
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    bus.arready_m_inf = 1;
    bus.rvalid_m_inf = 1;
    bus.rlast_m_inf = 1;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        settle();
        if (bus.req0_ready || bus.req1_ready) begin
          found = 1;
          chk("tie_grant", bus.req1_ready, g % 2);
        end
        tick();
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL tie_timeout: got no grant expected grant %0d", g % 2);
      end
    end
    tgt = 0;
    for (int c = 0; c < 5000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      bus.req0_valid = ($urandom_range(0, 99) < 40);
      bus.req1_valid = ($urandom_range(0, 99) < 40);
      bus.req0_addr = $urandom;
      bus.req1_addr = $urandom;
      bus.req0_len = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      bus.req1_len = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      bus.arready_m_inf = $urandom_range(0, 1);
      bus.rvalid_m_inf = ($urandom_range(0, 99) < 70);
      bus.rdata_m_inf = DW'($urandom);
      bus.rid_m_inf = IW'($urandom);
      bus.rresp_m_inf = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (m_active && !m_ar_done) begin
        int r;
        r = $urandom_range(0, 99);
        tgt = (r < 85) ? m_len
            : (r < 93) ? ((m_len == 0) ? 0 : $urandom_range(0, m_len - 1))
            : m_len + $urandom_range(1, 140);
      end
      bus.rlast_m_inf = (m_active && m_ar_done) ? (m_total == tgt) : 1'($urandom_range(0, 1));
      settle();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
